// File: rtl/dpd_pkg.sv
// Shared types and constants for the DPD coefficient controller:
// coefficient type, address map sizes, identity value and FSM states.
package dpd_pkg;

    localparam int COEF_W = 18;
    localparam int N_ORD  = 5;
    localparam int N_MEM  = 3;
    localparam int N_COEF = N_ORD * N_MEM;
    localparam int ADDR_W = 4;

    typedef logic signed [19:0]       s20_t;
    typedef logic        [19:0]       u20_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Unity gain in Q(COEF_W-2): 2^(COEF_W-2)
    localparam coef_t COEF_IDENT = {2'b01, {(COEF_W-2){1'b0}}};

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_COEF - 1);
    localparam logic [ADDR_W-1:0] COEF_SPAN = ADDR_W'(N_COEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/dpd_coef_bank.sv
// Two coefficient banks with identity reset: writes go to the shadow bank,
// the registered read port serves the active bank selected by bank_sel.
module dpd_coef_bank
    import dpd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  coef_t             wr_i,
    input  coef_t             wr_q,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output coef_t             rd_i,
    output coef_t             rd_q,
    output logic              bank_sel
);

    coef_t mem_i [2][N_COEF];
    coef_t mem_q [2][N_COEF];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_COEF; k++) begin
                mem_i[0][k] <= (k == 0) ? COEF_IDENT : '0;
                mem_i[1][k] <= (k == 0) ? COEF_IDENT : '0;
                mem_q[0][k] <= '0;
                mem_q[1][k] <= '0;
            end
            bank_sel <= 1'b0;
            rd_i     <= '0;
            rd_q     <= '0;
        end else begin
            if (wr_en && (wr_addr < COEF_SPAN)) begin
                mem_i[~bank_sel][wr_addr] <= wr_i;
                mem_q[~bank_sel][wr_addr] <= wr_q;
            end
            if (swap) begin
                bank_sel <= ~bank_sel;
            end
            // Read uses the pre-swap bank_sel, so a read on the swap edge sees the old bank
            if (rd_addr < COEF_SPAN) begin
                rd_i <= mem_i[bank_sel][rd_addr];
                rd_q <= mem_q[bank_sel][rd_addr];
            end else begin
                rd_i <= '0;
                rd_q <= '0;
            end
        end
    end

endmodule

// File: rtl/dpd_coef_ctrl.sv
// Double-buffered DPD coefficient controller: load FSM, framing check and swap.
// Optional macro DPD_COEF_SWAP_IMMEDIATE_EN swaps right after a set completes.
module dpd_coef_ctrl
    import dpd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [COEF_W-1:0] ld_data_i,
    input  logic [COEF_W-1:0] ld_data_q,
    input  logic              ld_last,
    input  logic              frame_sync,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COEF_W-1:0] rd_coef_i,
    output logic [COEF_W-1:0] rd_coef_q,
    output logic              bank_sel,
    output logic              swap_done,
    input  logic              err_clr,
    output logic              load_err
);

    // Handshake: a beat transfers on a rising edge where ld_valid && ld_ready;
    // ld_valid must not depend on ld_ready, ld_ready never depends on ld_valid.
    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              beat, swap, err_set;
    coef_t             rd_i, rd_q;

    assign ld_ready = ~reset & (state != ST_ARMED);
    assign beat     = ld_valid & ld_ready;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        err_set    = 1'b0;
        swap       = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (beat) begin
                    if (idx == LAST_IDX) begin
                        idx_next = '0;
                        if (ld_last) begin
                            state_next = ST_ARMED;
                        end else begin
                            err_set    = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else if (ld_last) begin
                        idx_next   = '0;
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_ARMED: begin
`ifdef DPD_COEF_SWAP_IMMEDIATE_EN
                swap = 1'b1;
`else
                swap = frame_sync;
`endif
                if (swap) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            swap_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            swap_done <= swap;
            // A new error wins over a simultaneous clear
            if (err_set) begin
                load_err <= 1'b1;
            end else if (err_clr) begin
                load_err <= 1'b0;
            end
        end
    end

    dpd_coef_bank u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (beat),
        .wr_addr  (idx),
        .wr_i     (coef_t'(ld_data_i)),
        .wr_q     (coef_t'(ld_data_q)),
        .swap     (swap),
        .rd_addr  (rd_addr),
        .rd_i     (rd_i),
        .rd_q     (rd_q),
        .bank_sel (bank_sel)
    );

    assign rd_coef_i = rd_i;
    assign rd_coef_q = rd_q;

endmodule

// File: tb/tb_dpd_coef_ctrl.sv
// Directed bench for dpd_coef_ctrl: read tables plus load/swap/error sequences.
module tb_dpd_coef_ctrl;
    import dpd_pkg::*;

    logic              clk;
    logic              reset;
    logic              ld_valid;
    logic              ld_ready;
    logic [COEF_W-1:0] ld_data_i;
    logic [COEF_W-1:0] ld_data_q;
    logic              ld_last;
    logic              frame_sync;
    logic [3:0]        rd_addr;
    logic [COEF_W-1:0] rd_coef_i;
    logic [COEF_W-1:0] rd_coef_q;
    logic              bank_sel;
    logic              swap_done;
    logic              err_clr;
    logic              load_err;

    typedef struct {
        logic [3:0] addr;
        int         exp_i;
        int         exp_q;
    } rd_vec_t;

    rd_vec_t tab_ident [16];
    rd_vec_t tab_a     [16];

    int n_tests = 0;
    int n_fail  = 0;

    dpd_coef_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data_i  (ld_data_i),
        .ld_data_q  (ld_data_q),
        .ld_last    (ld_last),
        .frame_sync (frame_sync),
        .rd_addr    (rd_addr),
        .rd_coef_i  (rd_coef_i),
        .rd_coef_q  (rd_coef_q),
        .bank_sel   (bank_sel),
        .swap_done  (swap_done),
        .err_clr    (err_clr),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_chk(input logic [3:0] a, input int ei, input int eq, input string name);
        rd_addr = a;
        tick(1);
        check({name, "_i"}, int'($signed(rd_coef_i)), ei);
        check({name, "_q"}, int'($signed(rd_coef_q)), eq);
    endtask

    task automatic run_table(input bit use_ident, input string tag);
        for (int k = 0; k < 16; k++) begin
            rd_vec_t v;
            v = use_ident ? tab_ident[k] : tab_a[k];
            read_chk(v.addr, v.exp_i, v.exp_q, $sformatf("%s_%0d", tag, k));
        end
    endtask

    // Sends n_beats beats with value k*100+off (q negated if q_neg)
    task automatic load_set(input int n_beats, input int last_beat, input int off,
                            input bit q_neg, input bit rand_valid, input bit fs_last);
        for (int k = 0; k < n_beats; k++) begin
            int  v;
            int  cyc;
            bit  acc;
            bit  acc_now;
            v         = k * 100 + off;
            ld_data_i = COEF_W'(v);
            ld_data_q = q_neg ? COEF_W'(-v) : COEF_W'(v);
            ld_last   = (k == last_beat);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 50) begin
                ld_valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                frame_sync = fs_last && (k == last_beat) && ld_valid;
                acc_now    = ld_valid && ld_ready;
                tick(1);
                acc = acc_now;
                cyc++;
            end
            if (!acc) begin
                check($sformatf("beat_timeout_%0d", k), 0, 1);
            end
        end
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_data_i  = '0;
        ld_data_q  = '0;
        ld_last    = 1'b0;
        frame_sync = 1'b0;
        rd_addr    = '0;
        err_clr    = 1'b0;

        for (int k = 0; k < 16; k++) begin
            tab_ident[k] = '{addr: 4'(k), exp_i: (k == 0) ? 65536 : 0, exp_q: 0};
            tab_a[k]     = '{addr: 4'(k), exp_i: (k < 15) ? k * 100 + 1 : 0,
                             exp_q: (k < 15) ? k * 100 + 1 : 0};
        end

        // Reset state
        tick(3);
        check("rst_ready", int'(ld_ready), 0);
        check("rst_rd_i", int'(rd_coef_i), 0);
        check("rst_rd_q", int'(rd_coef_q), 0);
        check("rst_bank_sel", int'(bank_sel), 0);
        check("rst_swap_done", int'(swap_done), 0);
        check("rst_load_err", int'(load_err), 0);
        reset = 1'b0;
        tick(1);
        check("post_rst_ready", int'(ld_ready), 1);
        run_table(1'b1, "ident");

        // Full good set, swap 5 cycles later
        load_set(15, 14, 1, 1'b0, 1'b0, 1'b0);
        check("a_ready_drop", int'(ld_ready), 0);
        check("a_load_err", int'(load_err), 0);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("a_wait_bank_%0d", c), int'(bank_sel), 0);
            check($sformatf("a_wait_sd_%0d", c), int'(swap_done), 0);
        end
        rd_addr    = 4'd7;
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        check("a_swap_done", int'(swap_done), 1);
        check("a_bank_sel", int'(bank_sel), 1);
        check("a_swap_edge_old_i", int'($signed(rd_coef_i)), 0);
        tick(1);
        check("a_new_i7", int'($signed(rd_coef_i)), 701);
        check("a_new_q7", int'($signed(rd_coef_q)), 701);
        check("a_sd_single", int'(swap_done), 0);
        check("a_ready_back", int'(ld_ready), 1);
        run_table(1'b0, "set_a");

        // Early ld_last on beat 9 -> framing error, no swap
        load_set(10, 9, 7, 1'b0, 1'b0, 1'b0);
        check("err_set", int'(load_err), 1);
        check("err_ready", int'(ld_ready), 1);
        pulse_fs();
        check("err_no_sd", int'(swap_done), 0);
        tick(1);
        check("err_bank_kept", int'(bank_sel), 1);
        read_chk(4'd7, 701, 701, "err_rd7");

        // Single-beat set with err_clr in the same cycle: error wins
        ld_valid  = 1'b1;
        ld_last   = 1'b1;
        ld_data_i = '0;
        ld_data_q = '0;
        err_clr   = 1'b1;
        tick(1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        err_clr  = 1'b0;
        check("clr_vs_err", int'(load_err), 1);
        check("single_beat_idle", int'(ld_ready), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_cleared", int'(load_err), 0);

        // Good set with random valid, q negated
        load_set(15, 14, 3, 1'b1, 1'b1, 1'b0);
        check("c_load_err", int'(load_err), 0);
        pulse_fs();
        check("c_swap_done", int'(swap_done), 1);
        check("c_bank_sel", int'(bank_sel), 0);
        for (int k = 0; k < 16; k++) begin
            read_chk(4'(k), (k < 15) ? k * 100 + 3 : 0, (k < 15) ? -(k * 100 + 3) : 0,
                     $sformatf("set_c_%0d", k));
        end

        // frame_sync coincident with the final beat does not swap
        load_set(15, 14, 5, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("d_no_swap_sd_%0d", c), int'(swap_done), 0);
            check($sformatf("d_no_swap_bank_%0d", c), int'(bank_sel), 0);
            tick(1);
        end
        pulse_fs();
        check("d_swap_done", int'(swap_done), 1);
        check("d_bank_sel", int'(bank_sel), 1);
        read_chk(4'd14, 1405, 1405, "d_rd14");

        // Reset in the middle of a load
        load_set(7, 99, 11, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(2);
        check("mid_rst_ready", int'(ld_ready), 0);
        reset = 1'b0;
        tick(1);
        check("mid_rst_bank_sel", int'(bank_sel), 0);
        check("mid_rst_load_err", int'(load_err), 0);
        run_table(1'b1, "mid_ident");
        load_set(15, 14, 9, 1'b1, 1'b0, 1'b0);
        check("e_load_err", int'(load_err), 0);
        pulse_fs();
        check("e_bank_sel", int'(bank_sel), 1);
        read_chk(4'd0, 9, -9, "e_rd0");
        read_chk(4'd14, 1409, -1409, "e_rd14");
        read_chk(4'd15, 0, 0, "e_rd15");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpd_coef_ctrl.md
# dpd_coef_ctrl

Double-buffered coefficient controller for the DPD polynomial stage.
- A host loads a full complex coefficient set into a shadow bank over a valid/ready stream.
- The controller swaps the shadow bank into service on a frame boundary.
- It serves per-cycle coefficient reads to the polynomial combiner that weights the magnitude-power terms (|x|^0..|x|^4) per memory tap.
- It sits between the host/config interface and the DPD datapath, so the datapath never sees a partially written coefficient set.

## Interface
Parameters:
- N_ORD, 5, number of magnitude-power orders (matches mag_0..mag_4)
- N_MEM, 3, memory taps per order
- COEF_W, 18, signed coefficient width per I/Q component

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  host beat valid
- ld_ready  out  1  controller accepts beat
- ld_data_i  in  COEF_W  coefficient real part, signed
- ld_data_q  in  COEF_W  coefficient imaginary part, signed
- ld_last  in  1  final beat of a set
- frame_sync  in  1  one-cycle frame boundary strobe from datapath
- rd_addr  in  4  coefficient index, ord*N_MEM+tap
- rd_coef_i  out  COEF_W  active-bank real part, registered
- rd_coef_q  out  COEF_W  active-bank imaginary part, registered
- bank_sel  out  1  index of active bank
- swap_done  out  1  one-cycle pulse when a new bank goes active
- err_clr  in  1  clears load_err
- load_err  out  1  sticky framing error

## Operation
- N_COEF = N_ORD*N_MEM = 15. Address map is idx = ord*N_MEM + tap. Beat k of a set writes shadow index k.
- FSM states and transitions:
  - IDLE: ld_ready=1. The first accepted beat writes idx 0 and goes to LOAD.
  - LOAD: ld_ready=1. Each accepted beat writes the next idx. Correct completion (ld_last on the beat writing idx N_COEF-1) goes to ARMED.
  - ARMED: ld_ready=0. frame_sync toggles bank_sel, pulses swap_done, and goes to IDLE.
- Framing error: ld_last on a beat with idx != N_COEF-1, or no ld_last on the idx N_COEF-1 beat.
  - load_err is set and the FSM goes to IDLE.
  - The shadow bank is never activated. The next set restarts at idx 0.
- A single-beat set with ld_last at idx 0 is an error unless N_COEF = 1.
- load_err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, load_err stays 1.
- Reset values:
  - Both banks are loaded with identity: idx 0 = (2^(COEF_W-2), 0) = (65536, 0) for COEF_W=18; all other indices are 0.
  - bank_sel=0, state IDLE, ld_ready=0 during reset and 1 from the first cycle after.
  - rd_coef_i/q=0, swap_done=0, load_err=0.
- Reads:
  - rd_coef is registered from the active bank at rd_addr.
  - rd_addr >= N_COEF returns 0.
- Reset mid-load discards the partial set. Both banks return to identity.

## Timing
- Load handshake: a beat transfers on a rising edge with ld_valid && ld_ready. ld_valid must not depend on ld_ready.
- Write visibility: a written shadow entry is visible only after the swap.
- Read latency: 1 cycle, rd_addr at edge n gives rd_coef after edge n.
- Swap edge:
  - bank_sel and swap_done update on the edge after frame_sync is sampled in ARMED.
  - A read sampled on that same edge returns old-bank data. The next read returns new-bank data.
- frame_sync outside ARMED is ignored.
- frame_sync in the same cycle as the final beat does not swap. The swap waits for the next frame_sync.
- Back-to-back sets: the earliest next accepted beat is the cycle after swap_done.

## Configuration
- DPD_COEF_SWAP_IMMEDIATE_EN:
  - Defined: ARMED swaps on the edge after entry, ignoring frame_sync. Minimum load-to-active time is 1 cycle after the last beat.
  - Undefined: the swap is gated by frame_sync as above.

## Structure
- dpd_pkg holds:
  - s20/u20 typedefs and the coefficient typedef (signed [COEF_W-1:0])
  - N_ORD, N_MEM, N_COEF, COEF_IDENT = 2^(COEF_W-2)
  - FSM state enum
- One sub-module, dpd_coef_bank: two register banks with identity reset, one write port to the shadow bank, one registered read port on the active bank, and bank select.
- dpd_coef_ctrl holds the FSM, index counter, error logic and swap logic.

## Test plan
- Reset, then read idx 0..15: idx 0 → (65536, 0), idx 1..14 → 0, idx 15 → 0; bank_sel=0.
- Load 15 beats with value k*100+1 for idx k, ld_last on beat 14, then frame_sync 5 cycles later.
  - ld_ready drops after beat 14.
  - swap_done pulses once and bank_sel=1.
  - Read idx 7 → (701, 701); a read issued on the swap edge returns the old value 0.
- ld_last on beat 9: load_err=1, no swap on a later frame_sync. A following good 15-beat set loads and swaps normally.
- Pseudo-random ld_valid (50%) over a full set: all 15 values land at the correct indices.
- frame_sync coincident with the last beat: no swap; the swap happens on the next frame_sync.
- Reset asserted mid-load at beat 6: both banks return to identity, bank_sel=0, and a fresh load starts at idx 0.
